// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with per-frame error flags,
// break/overrun pulses and a show-ahead valid/ready receive FIFO.
// Ports: clk, reset (sync, active high), uart_rxd, uart_rx_en,
//   uart_rx_data/perr/ferr/valid, uart_rx_ready, uart_rx_break,
//   uart_rx_overrun, fifo_count.
// Optional: define UART_RX_PARITY_EN to expect a parity bit per frame.
module uart_rx_param #(
  parameter int CLK_HZ       = 48000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_rxd,
  input  logic                          uart_rx_en,
  output logic [PAYLOAD_BITS-1:0]       uart_rx_data,
  output logic                          uart_rx_perr,
  output logic                          uart_rx_ferr,
  output logic                          uart_rx_valid,
  input  logic                          uart_rx_ready,
  output logic                          uart_rx_break,
  output logic                          uart_rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
`ifdef UART_RX_PARITY_EN
  localparam int EW  = PAYLOAD_BITS + 2;
`else
  localparam int EW  = PAYLOAD_BITS + 1;
`endif
  localparam logic [CW-1:0] HALF = CW'(CPB / 2);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t r_state, w_next;

  logic                    r_s1, r_rxs, r_rxs_prev;
  logic [CW-1:0]           r_cnt;
  logic [3:0]              r_bit;
  logic [PAYLOAD_BITS-1:0] r_data;
  logic                    r_ferr;
  logic                    r_any1;
  logic                    r_lock;
  logic                    r_push;
  logic                    r_brk;
`ifdef UART_RX_PARITY_EN
  logic                    r_pbit;
`endif

  logic w_fell, w_clr, w_smp, w_done, w_ones;
  logic w_perr, w_pop, w_full, w_wr;
  logic [EW-1:0] w_entry, w_head;

  logic [EW-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr, r_rd;
  logic [AW:0]    r_count;

  assign w_fell = r_rxs_prev & ~r_rxs;
  // a frame that saw any 1 bit is data; all zeros is a break
  assign w_ones = r_any1 | r_rxs;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_smp  = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_clr = 1'b1;
        if (w_fell && uart_rx_en && !r_lock)
          w_next = S_START;
      end
      S_START: begin
        if (r_cnt == HALF) begin
          w_clr  = 1'b1;
          w_next = r_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == LAST) begin
          w_clr = 1'b1;
          w_smp = 1'b1;
          if (r_bit == 4'(PAYLOAD_BITS - 1))
`ifdef UART_RX_PARITY_EN
            w_next = S_PARITY;
`else
            w_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == LAST) begin
          w_clr  = 1'b1;
          w_smp  = 1'b1;
          w_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (r_cnt == LAST) begin
          w_clr = 1'b1;
          w_smp = 1'b1;
          if (r_bit == 4'(STOP_BITS - 1)) begin
            w_next = S_IDLE;
            w_done = 1'b1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1       <= 1'b1;
      r_rxs      <= 1'b1;
      r_rxs_prev <= 1'b1;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_data     <= '0;
      r_ferr     <= 1'b0;
      r_any1     <= 1'b0;
      r_lock     <= 1'b0;
      r_push     <= 1'b0;
      r_brk      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pbit     <= 1'b0;
`endif
    end else begin
      r_s1       <= uart_rxd;
      r_rxs      <= r_s1;
      r_rxs_prev <= r_rxs;
      r_cnt      <= w_clr ? '0 : r_cnt + 1'b1;
      if (r_state == S_IDLE) begin
        r_bit  <= '0;
        r_ferr <= 1'b0;
        r_any1 <= 1'b0;
      end
      if (w_smp) begin
        // bit index restarts whenever the sampled field changes
        r_bit <= (w_next != r_state) ? '0 : r_bit + 1'b1;
        if (r_rxs) r_any1 <= 1'b1;
        if (r_state == S_DATA)
          r_data <= {r_rxs, r_data[PAYLOAD_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
        if (r_state == S_PARITY)
          r_pbit <= r_rxs;
`endif
        if (r_state == S_STOP && !r_rxs)
          r_ferr <= 1'b1;
      end
      r_push <= w_done & w_ones;
      r_brk  <= w_done & ~w_ones;
      // after a break the line must return high before a new start
      if (w_done && !w_ones) r_lock <= 1'b1;
      else if (r_rxs)        r_lock <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  assign w_perr  = ((^r_data) ^ r_pbit) != PARITY_ODD[0];
  assign w_entry = {w_perr, r_ferr, r_data};
`else
  assign w_perr  = 1'b0;
  assign w_entry = {r_ferr, r_data};
`endif

  assign w_pop  = uart_rx_valid & uart_rx_ready;
  assign w_full = r_count == (AW + 1)'(FIFO_DEPTH);
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_wr   = r_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign w_head          = r_mem[r_rd];
  assign uart_rx_valid   = r_count != '0;
  assign uart_rx_data    = uart_rx_valid ? w_head[PAYLOAD_BITS-1:0] : '0;
  assign uart_rx_ferr    = uart_rx_valid & w_head[PAYLOAD_BITS];
`ifdef UART_RX_PARITY_EN
  assign uart_rx_perr    = uart_rx_valid & w_head[PAYLOAD_BITS+1];
`else
  assign uart_rx_perr    = 1'b0;
`endif
  assign uart_rx_break   = r_brk;
  assign uart_rx_overrun = r_push & w_full & ~w_pop;
  assign fifo_count      = r_count;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: randomized scoreboard bench for uart_rx_param.
// Frames are modelled at the line level; a monitor pops on handshakes.
module tb_uart_rx_param;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int PB    = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int ODD = 0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rxd = 1'b1;
  logic          en = 1'b1;
  logic          rdy = 1'b1;
  logic [PB-1:0] dout;
  logic          perr, ferr, valid, brk, ovr;
  logic [2:0]    cnt;

  uart_rx_param #(
    .CLK_HZ(1600000), .BIT_RATE(100000), .PAYLOAD_BITS(PB),
    .STOP_BITS(1), .PARITY_ODD(ODD), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .uart_rxd(rxd), .uart_rx_en(en),
    .uart_rx_data(dout), .uart_rx_perr(perr), .uart_rx_ferr(ferr),
    .uart_rx_valid(valid), .uart_rx_ready(rdy),
    .uart_rx_break(brk), .uart_rx_overrun(ovr), .fifo_count(cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_brk = 0, exp_ovr = 0, seen_brk = 0, seen_ovr = 0;
  logic [PB+1:0] exp_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // reference: what the receiver should make of one frame
  function automatic void model(input logic [PB-1:0] d,
                                input logic pb, input logic stp);
    logic e_perr, e_brk;
    if (!en) return;
    e_perr = PAR && ((($countones(d) + pb) % 2) != ODD);
    e_brk  = (d == 0) && (!PAR || !pb) && !stp;
    if (e_brk) exp_brk++;
    else if (!rdy && exp_q.size() == DEPTH) exp_ovr++;
    else exp_q.push_back({e_perr, ~stp, d});
  endfunction

  function automatic logic good_par(input logic [PB-1:0] d);
    return 1'(($countones(d) + ODD) % 2);
  endfunction

  task automatic bitt(input logic b, input int n);
    rxd = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PB-1:0] d,
                      input logic pb, input logic stp);
    model(d, pb, stp);
    bitt(1'b0, CPB);
    for (int i = 0; i < PB; i++) bitt(d[i], CPB);
    if (PAR) bitt(pb, CPB);
    bitt(stp, CPB);
    bitt(1'b1, CPB);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // scoreboard monitor, sampled on the falling edge
  logic prev_brk = 1'b0, prev_ovr = 1'b0;
  always @(negedge clk) begin
    if (!reset && valid && rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 1, 0);
      end else begin
        logic [PB+1:0] e;
        e = exp_q.pop_front();
        chk("pop_data", int'(dout), int'(e[PB-1:0]));
        chk("pop_ferr", int'(ferr), int'(e[PB]));
        chk("pop_perr", int'(perr), int'(e[PB+1]));
      end
    end
    if (brk) begin
      seen_brk++;
      chk("brk_1cyc", int'(prev_brk), 0);
    end
    if (ovr) begin
      seen_ovr++;
      chk("ovr_1cyc", int'(prev_ovr), 0);
    end
    prev_brk = brk;
    prev_ovr = ovr;
  end

  initial begin
    logic [PB-1:0] d;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_count", int'(cnt), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_data", int'(dout), 0);
    chk("rst_flags", int'({perr, ferr, brk, ovr}), 0);
    @(posedge clk); #1;
    bitt(1'b1, 4);

    send(8'hA5, good_par(8'hA5), 1'b1);
    drain();
    chk("a5_count", int'(cnt), 0);

    rdy = 1'b0;
    for (int i = 1; i <= 5; i++)
      send(PB'(i), good_par(PB'(i)), 1'b1);
    chk("ovr_count", int'(cnt), DEPTH);
    chk("ovr_seen", seen_ovr, exp_ovr);
    rdy = 1'b1;
    drain();
    chk("ovr_drain_cnt", int'(cnt), 0);

    send(8'h3C, good_par(8'h3C), 1'b0);
    drain();

    model(8'h00, 1'b0, 1'b0);
    bitt(1'b0, 12 * CPB);
    bitt(1'b1, 2 * CPB);
    chk("brk_seen", seen_brk, exp_brk);
    chk("brk_count", int'(cnt), 0);
    send(8'h55, good_par(8'h55), 1'b1);
    drain();

    if (PAR) begin
      send(8'h07, 1'b0, 1'b1);
      send(8'h07, 1'b1, 1'b1);
      drain();
    end

    bitt(1'b0, 5);
    bitt(1'b1, 2 * CPB);
    chk("glitch_count", int'(cnt), 0);

    en = 1'b0;
    send(8'h99, good_par(8'h99), 1'b1);
    en = 1'b1;
    chk("en_off_count", int'(cnt), 0);

    for (int k = 0; k < 30; k++) begin
      d = PB'($urandom_range(0, 255));
      send(d, ($urandom_range(0, 7) == 0) ? ~good_par(d) : good_par(d),
           ($urandom_range(0, 5) != 0));
    end
    drain();
    chk("rand_brk", seen_brk, exp_brk);

    rdy = 1'b0;
    send(8'h11, good_par(8'h11), 1'b1);
    send(8'h22, good_par(8'h22), 1'b1);
    chk("pre_rst_count", int'(cnt), 2);
    bitt(1'b0, CPB);
    for (int i = 0; i < 4; i++) bitt(1'b1, CPB);
    reset = 1'b1;
    rxd = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_count", int'(cnt), 0);
    chk("midrst_valid", int'(valid), 0);
    @(posedge clk); #1;
    rdy = 1'b1;
    bitt(1'b1, CPB);
    send(8'h5A, good_par(8'h5A), 1'b1);
    drain();

    chk("final_brk", seen_brk, exp_brk);
    chk("final_ovr", seen_ovr, exp_ovr);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised successor to the fixed 8N1 UART receiver: configurable clock/bit rate, payload width (5–8), stop-bit count, optional parity, per-frame error flags and a show-ahead receive FIFO with valid/ready drain. Sits between the external `uart_rxd` pin and the bus/host-side consumer. Break and overrun are reported as single-cycle pulses.

## Interface
- `CLK_HZ`, 48000000, system clock frequency in Hz
- `BIT_RATE`, 9600, line rate in bps; `CPB = CLK_HZ/BIT_RATE` (truncated), must be ≥ 8
- `PAYLOAD_BITS`, 8, data bits per frame, legal 5..8
- `STOP_BITS`, 1, stop bits sampled, legal 1..2
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd; used only with `UART_RX_PARITY_EN`
- `FIFO_DEPTH`, 4, RX FIFO entries, power of two ≥ 2

Ports:
- `clk` in 1: system clock, all logic on rising edge
- `reset` in 1: synchronous, active-high reset
- `uart_rxd` in 1: asynchronous serial line, idle high
- `uart_rx_en` in 1: gates start-bit detection only
- `uart_rx_data` out PAYLOAD_BITS: head-of-FIFO payload
- `uart_rx_perr` out 1: head entry parity error (0 when parity compiled out)
- `uart_rx_ferr` out 1: head entry framing error
- `uart_rx_valid` out 1: FIFO non-empty
- `uart_rx_ready` in 1: consumer accepts head when high with valid
- `uart_rx_break` out 1: one-cycle break pulse
- `uart_rx_overrun` out 1: one-cycle pulse, frame dropped on full FIFO
- `fifo_count` out $clog2(FIFO_DEPTH)+1: occupied entries

## Operation
- `uart_rxd` passes a 2-FF synchroniser (reset value 1); all logic uses the synchronised signal `rxs` and its previous value.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: counter cleared; on `rxs` 1→0 with `uart_rx_en`=1 → START.
- START: at count `CPB/2` sample; `rxs`=1 → IDLE (glitch rejected), else counter cleared → DATA.
- DATA: sample every `CPB` cycles, LSB first, `PAYLOAD_BITS` samples → PARITY if compiled in, else STOP.
- PARITY: one sample at `CPB`; `perr` = XOR(data, parity bit) ≠ `PARITY_ODD`.
- STOP: `STOP_BITS` samples at `CPB` spacing; any 0 sets `ferr`. After last sample → IDLE.
- Break: all data bits, parity bit (if present) and every stop sample 0 → `uart_rx_break` pulses, no FIFO write. FSM stays in IDLE until `rxs` has been 1 for at least one cycle before a new start is accepted.
- Otherwise frame `{perr, ferr, data}` is pushed; frames with errors are still stored.
- FIFO full at push with no pop in same cycle → frame dropped, `uart_rx_overrun` pulses, contents unchanged.
- Pop when `uart_rx_valid && uart_rx_ready`. Push and pop in the same cycle are both honoured, including when full: no overrun.
- Deasserting `uart_rx_en` mid-frame does not abort; the frame completes normally.

## Timing
- Reset values: FSM IDLE, FIFO empty, `fifo_count`=0, `uart_rx_valid`=0, `uart_rx_data`=0, `uart_rx_perr`=`uart_rx_ferr`=0, `uart_rx_break`=`uart_rx_overrun`=0.
- Reset mid-frame: the frame is discarded and the FIFO is flushed on the next edge.
- Pin-to-FSM latency: 2 cycles through the synchroniser.
- Push occurs the cycle after the final stop sample. `uart_rx_valid` and head data update the cycle after the push; there is no bypass from an empty FIFO.
- Break and overrun pulses are asserted in the cycle after the final stop sample, for exactly 1 cycle.
- `fifo_count` updates the cycle after a push or pop; it is unchanged on a simultaneous push and pop.
- Head outputs are stable while `uart_rx_valid`=1 and `uart_rx_ready`=0.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state is present; a frame is start + data + parity + stop; `uart_rx_perr` is live.
- `UART_RX_PARITY_EN` undefined: no PARITY state and no parity bit is expected; `uart_rx_perr` is tied to 0; the FIFO entry width drops by 1.

## Test plan
Defaults unless stated: 48 MHz clock, 9600 bps, CPB=5000.
- Send 0xA5, 8N1, ready=1 → exactly one valid cycle with data 0xA5, perr=0, ferr=0, count returns to 0.
- Ready=0; send 0x01–0x04 then 0x05 → count=4, overrun pulses once, 0x05 dropped; drain yields 0x01, 0x02, 0x03, 0x04 in order.
- Send 0x3C with stop bit held 0, then line high → entry 0x3C, ferr=1, no break.
- Hold line low for 12 bit periods → break pulses once, count stays 0. A following 0x55 is received correctly.
- With macro, even parity: 0x07 with parity bit 0 → perr=1; 0x07 with parity bit 1 → perr=0.
- 1000-cycle low glitch → no frame. Assert reset in the middle of the DATA state with 2 entries queued → next cycle count=0, valid=0, FSM IDLE.
